// File: rtl/float_div_nr_if.sv
// Valid/ready operand and result channels of the Newton-Raphson float divider.
interface float_div_nr_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] C;
   logic [4:0]            flags;

   modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, C, flags);
   modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, C, flags);
endinterface

// File: rtl/float_div_nr.sv
// IEEE-754 divider C = A / B: fixed-point Newton-Raphson reciprocal, remainder
// correction and RNE rounding, flush-to-zero, one operation in flight.
module float_div_nr #(
   parameter int DATA_WIDTH = 32,
   parameter int NR_ITERS   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   float_div_nr_if.slave bus
);
   localparam int EXP  = (DATA_WIDTH == 16) ? 5 : (DATA_WIDTH == 32) ? 8 : 11;
   localparam int MANT = DATA_WIDTH - EXP - 1;
   localparam int BIAS = (1 << (EXP - 1)) - 1;
   localparam int IW   = 2 * MANT + 6;
   localparam int XW   = IW + 2;
   localparam int XW6  = XW + 6;
   localparam int RW   = 2 * MANT + 6;
   localparam int QW   = MANT + 3;
   localparam int EW   = EXP + 2;
   localparam int MIN_ITERS = (DATA_WIDTH == 16) ? 2 : (DATA_WIDTH == 32) ? 3 : 4;

   generate
      if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
         $error("float_div_nr: DATA_WIDTH must be 16, 32 or 64");
      end
      if (NR_ITERS < MIN_ITERS) begin : g_bad_iters
         $error("float_div_nr: NR_ITERS too small for DATA_WIDTH");
      end
   endgenerate

   localparam logic [XW6-1:0] ONE_W = XW6'(1);
   localparam logic [XW-1:0]  K48   = XW'(((ONE_W << IW) * XW6'(48)) / XW6'(17));
   localparam logic [XW-1:0]  K32   = XW'(((ONE_W << IW) * XW6'(32)) / XW6'(17));
   localparam logic [XW-1:0]  TWO   = XW'(ONE_W << (IW + 1));
   localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP) - 1);
   localparam logic signed [EW-1:0] ONE_E  = EW'(1);
   localparam logic signed [EW-1:0] ZERO_E = '0;
   localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};

   typedef enum logic [3:0] {IDLE, UNPACK, SEED, ITER_MUL, ITER_SUB, QUOT, CORR, ROUND, DONE} state_t;
   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] a_q, b_q, c_q, c_d, byp_c_q, byp_c_d;
   logic [4:0]            flags_q, flags_d, byp_f_q, byp_f_d;
   logic                  sign_q, byp_q, byp_d, stk_q;
   logic [EXP-1:0]        ea_q, eb_q;
   logic [MANT:0]         ma_q, mb_q;
   logic [XW-1:0]         d_q, x_q, t_q, d_seed, mul_a, mul_b;
   logic [2*XW-1:0]       prod;
   logic [QW-1:0]         q_q, q_corr, m_n;
   logic [7:0]            it_q;
   logic                  a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan, s_ab;
   logic signed [RW-1:0]  r_raw, mb_s;
   logic                  stk_corr, lt;
   logic signed [EW-1:0]  e0;
   logic [DATA_WIDTH+4:0] rnd_res;
   logic                  unused_prod;

   // Returns {flags, result}; m holds hidden+mantissa+guard+round, already normalised.
   function automatic logic [DATA_WIDTH+4:0] round_pack(input logic s, input logic signed [EW-1:0] e_in,
                                                        input logic [QW-1:0] m, input logic sticky);
      logic [MANT+1:0]      sum;
      logic signed [EW-1:0] e;
      logic                 inexact, unused_hidden;
      inexact = m[1] | m[0] | sticky;
      sum = {1'b0, m[QW-1:2]} + {{(MANT+1){1'b0}}, m[1] & (m[0] | sticky | m[2])};
      unused_hidden = sum[MANT];
      e = e_in + {{(EW-1){1'b0}}, sum[MANT+1]};
      if (e >= EMAX) return {5'b00101, s, {EXP{1'b1}}, {MANT{1'b0}}};
      if (e < ONE_E) return {5'b00011, s, {(DATA_WIDTH-1){1'b0}}};
      return {4'b0000, inexact, s, e[EXP-1:0], sum[MANT-1:0]};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q     <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      flags_d = flags_q;
      case (state_q)
         IDLE:     if (bus.in_valid) state_d = UNPACK;
         UNPACK:   state_d = SEED;
         SEED:     state_d = ITER_MUL;
         ITER_MUL: state_d = ITER_SUB;
         ITER_SUB: state_d = (it_q == 8'(NR_ITERS - 1)) ? QUOT : ITER_MUL;
         QUOT:     state_d = CORR;
         CORR:     state_d = ROUND;
         ROUND: begin
            state_d          = DONE;
            {flags_d, c_d}   = byp_q ? {byp_f_q, byp_c_q} : rnd_res;
         end
         DONE:     if (bus.out_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = rst_n && (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.C         = c_q;
   assign bus.flags     = flags_q;

   // Special operands resolve here; the datapath still runs so latency stays fixed.
   always_comb begin
      a_zero  = (a_q[DATA_WIDTH-2:MANT] == '0);
      b_zero  = (b_q[DATA_WIDTH-2:MANT] == '0);
      a_inf   = (a_q[DATA_WIDTH-2:MANT] == '1) && (a_q[MANT-1:0] == '0);
      b_inf   = (b_q[DATA_WIDTH-2:MANT] == '1) && (b_q[MANT-1:0] == '0);
      a_nan   = (a_q[DATA_WIDTH-2:MANT] == '1) && (a_q[MANT-1:0] != '0);
      b_nan   = (b_q[DATA_WIDTH-2:MANT] == '1) && (b_q[MANT-1:0] != '0);
      a_snan  = a_nan && !a_q[MANT-1];
      b_snan  = b_nan && !b_q[MANT-1];
      s_ab    = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
      byp_d   = 1'b1;
      byp_f_d = '0;
      byp_c_d = QNAN;
      if (a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         byp_f_d = 5'b10000;
      end else if (a_nan || b_nan) begin
         byp_c_d = QNAN;
      end else if (b_zero && !a_inf) begin
         byp_c_d = {s_ab, {EXP{1'b1}}, {MANT{1'b0}}};
         byp_f_d = 5'b01000;
      end else if (a_inf) begin
         byp_c_d = {s_ab, {EXP{1'b1}}, {MANT{1'b0}}};
      end else if (b_inf || a_zero) begin
         byp_c_d = {s_ab, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         byp_d   = 1'b0;
      end
   end

   // One multiplier shared by seed, both iteration halves and the quotient.
   assign d_seed = XW'(mb_q) << (IW - MANT - 1);
   always_comb begin
      mul_a = d_q;
      mul_b = x_q;
      case (state_q)
         SEED:     begin mul_a = K32;       mul_b = d_seed;     end
         ITER_SUB: begin mul_a = x_q;       mul_b = TWO - t_q;  end
         QUOT:     begin mul_a = XW'(ma_q); mul_b = x_q;        end
         default:  ;
      endcase
   end
   assign prod        = {{XW{1'b0}}, mul_a} * {{XW{1'b0}}, mul_b};
   assign unused_prod = ^{prod[IW-2:0], prod[2*XW-1:IW+XW]};

   always_comb begin
      mb_s     = $signed(RW'(mb_q));
      r_raw    = $signed(RW'(ma_q) << (MANT + 2)) - $signed(RW'(q_q) * RW'(mb_q));
      q_corr   = q_q;
      stk_corr = (r_raw != '0);
      if (r_raw[RW-1]) begin
         q_corr   = q_q - QW'(1);
         stk_corr = ((r_raw + mb_s) != '0);
      end else if (r_raw >= mb_s) begin
         q_corr   = q_q + QW'(1);
         stk_corr = ((r_raw - mb_s) != '0);
      end
   end

   assign lt      = (ma_q < mb_q);
   assign m_n     = lt ? {q_q[QW-2:0], 1'b0} : q_q;
   assign e0      = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_E - (lt ? ONE_E : ZERO_E);
   assign rnd_res = round_pack(sign_q, e0, m_n, stk_q);

   always_ff @(posedge clk) begin
      case (state_q)
         IDLE: if (bus.in_valid) begin
            a_q <= bus.A;
            b_q <= bus.B;
         end
         UNPACK: begin
            sign_q  <= s_ab;
            ea_q    <= a_q[DATA_WIDTH-2:MANT];
            eb_q    <= b_q[DATA_WIDTH-2:MANT];
            ma_q    <= {1'b1, a_q[MANT-1:0]};
            mb_q    <= {1'b1, b_q[MANT-1:0]};
            byp_q   <= byp_d;
            byp_c_q <= byp_c_d;
            byp_f_q <= byp_f_d;
         end
         SEED: begin
            d_q  <= d_seed;
            x_q  <= K48 - prod[IW+XW-1:IW];
            it_q <= '0;
         end
         ITER_MUL: t_q <= prod[IW+XW-1:IW];
         ITER_SUB: begin
            x_q  <= prod[IW+XW-1:IW];
            it_q <= it_q + 8'd1;
         end
         QUOT: q_q <= prod[IW+MANT+1:IW-1];
         CORR: begin
            q_q   <= q_corr;
            stk_q <= stk_corr;
         end
         default: ;
      endcase
   end
endmodule
